// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the hazard/forwarding controller.
// Scoreboard entries carry rd zero-extended to SB_RD_W bits.
package hazard_pkg;

    localparam int SB_RD_W = 8;
    localparam int FWD_RF  = 0;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               is_load;
    } sb_entry_t;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: priority matcher for one source operand against the scoreboard.
// Youngest matching entry wins; reports forwarding select and load-use.
import hazard_pkg::*;

module hazard_match #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = sel_width(FWD_DEPTH)
) (
    input  logic                       used,
    input  logic [REG_ADDR_W-1:0]      rs,
    input  sb_entry_t [FWD_DEPTH-1:0]  sb,
    output logic                       hit,
    output logic [SEL_W-1:0]           sel,
    output logic                       load_use
);

    logic [SB_RD_W-1:0] rs_ext;

    assign rs_ext = SB_RD_W'(rs);

    // Walk oldest to youngest so the youngest match overwrites.
    always_comb begin
        hit      = 1'b0;
        sel      = SEL_W'(FWD_RF);
        load_use = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (used && rs_ext != '0 && sb[k].valid && sb[k].rd == rs_ext) begin
                hit      = 1'b1;
                sel      = SEL_W'(k + 1);
                load_use = sb[k].is_load && (k < LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-based forwarding select, load-use interlock,
// branch flush and saturating stall/flush statistics.
import hazard_pkg::*;

module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = sel_width(FWD_DEPTH),
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic                  issue_rs1_used,
    input  logic                  issue_rs2_used,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_we,
    input  logic                  issue_is_load,
    input  logic                  branch_taken,
    output logic                  stall,
    output logic                  bubble,
    output logic                  flush,
    output logic [SEL_W-1:0]      fwd_sel_rs1,
    output logic [SEL_W-1:0]      fwd_sel_rs2,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    sb_entry_t [FWD_DEPTH-1:0] sb_q, sb_d;
    logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]          flush_cnt_q, flush_cnt_d;

    logic             hit1, hit2;
    logic             lu1, lu2;
    logic             lu_hit;
    logic [SEL_W-1:0] sel1, sel2;

    hazard_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_DEPTH  (FWD_DEPTH),
        .LOAD_LAT   (LOAD_LAT),
        .SEL_W      (SEL_W)
    ) u_match_rs1 (
        .used     (issue_rs1_used),
        .rs       (issue_rs1),
        .sb       (sb_q),
        .hit      (hit1),
        .sel      (sel1),
        .load_use (lu1)
    );

    hazard_match #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_DEPTH  (FWD_DEPTH),
        .LOAD_LAT   (LOAD_LAT),
        .SEL_W      (SEL_W)
    ) u_match_rs2 (
        .used     (issue_rs2_used),
        .rs       (issue_rs2),
        .sb       (sb_q),
        .hit      (hit2),
        .sel      (sel2),
        .load_use (lu2)
    );

    // Flush outranks the interlock; reset masks every control output.
    always_comb begin
        lu_hit      = issue_valid && (lu1 || lu2);
        flush       = reset && branch_taken;
        stall       = reset && lu_hit && !branch_taken;
        bubble      = flush || stall;
        fwd_sel_rs1 = (hit1 && !lu_hit) ? sel1 : SEL_W'(FWD_RF);
        fwd_sel_rs2 = (hit2 && !lu_hit) ? sel2 : SEL_W'(FWD_RF);
    end

    always_comb begin
        sb_d[0].valid   = issue_valid && issue_we && (issue_rd != '0)
                          && !stall && !flush;
        sb_d[0].rd      = SB_RD_W'(issue_rd);
        sb_d[0].is_load = issue_is_load;
        for (int k = 1; k < FWD_DEPTH; k++) begin
            sb_d[k] = sb_q[k-1];
        end
        stall_cnt_d = stall_cnt_q + CNT_W'(stall && !(&stall_cnt_q));
        flush_cnt_d = flush_cnt_q + CNT_W'(flush && !(&flush_cnt_q));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl (FWD_DEPTH=2, LOAD_LAT=1).
// Inputs change 1 time unit after each rising edge; outputs are checked before the next.
module tb_hazard_ctrl;

    localparam int RW = 5;
    localparam int SW = 2;
    localparam int CW = 16;

    logic          clk;
    logic          reset;
    logic          issue_valid;
    logic [RW-1:0] issue_rs1, issue_rs2, issue_rd;
    logic          issue_rs1_used, issue_rs2_used;
    logic          issue_we, issue_is_load, branch_taken;
    logic          stall, bubble, flush;
    logic [SW-1:0] fwd_sel_rs1, fwd_sel_rs2;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int nvec;
    int nerr;

    hazard_ctrl #(
        .REG_ADDR_W (RW),
        .FWD_DEPTH  (2),
        .LOAD_LAT   (1),
        .SEL_W      (SW),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_rs1_used (issue_rs1_used),
        .issue_rs2_used (issue_rs2_used),
        .issue_rd       (issue_rd),
        .issue_we       (issue_we),
        .issue_is_load  (issue_is_load),
        .branch_taken   (branch_taken),
        .stall          (stall),
        .bubble         (bubble),
        .flush          (flush),
        .fwd_sel_rs1    (fwd_sel_rs1),
        .fwd_sel_rs2    (fwd_sel_rs2),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int rs1, input logic u1,
                         input int rs2, input logic u2, input int rd,
                         input logic we, input logic ld, input logic br);
        issue_valid    = v;
        issue_rs1      = RW'(rs1);
        issue_rs1_used = u1;
        issue_rs2      = RW'(rs2);
        issue_rs2_used = u2;
        issue_rd       = RW'(rd);
        issue_we       = we;
        issue_is_load  = ld;
        branch_taken   = br;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nvec  = 0;
        nerr  = 0;
        reset = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        chk("rst_flush", 32'(flush), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_bubble", 32'(bubble), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_flush_cnt", 32'(flush_cnt), 0);
        chk("rst_sel1", 32'(fwd_sel_rs1), 0);
        idle();
        tick();
        #2 reset = 1'b1;
        tick();

        // ALU chain
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        #1 chk("alu_issue_stall", 32'(stall), 0);
        tick();
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        #1 chk("alu_sel1_d1", 32'(fwd_sel_rs1), 1);
        chk("alu_stall_d1", 32'(stall), 0);
        tick();
        drive(1, 0, 0, 5, 1, 0, 0, 0, 0);
        #1 chk("alu_sel2_d2", 32'(fwd_sel_rs2), 2);
        tick();
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        #1 chk("alu_sel1_d3", 32'(fwd_sel_rs1), 0);
        chk("alu_stall_d3", 32'(stall), 0);
        tick();

        // Load-use
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
        tick();
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0);
        #1 chk("lu_stall", 32'(stall), 1);
        chk("lu_bubble", 32'(bubble), 1);
        chk("lu_sel1_forced", 32'(fwd_sel_rs1), 0);
        tick();
        chk("lu_stall_cnt", 32'(stall_cnt), 1);
        chk("lu_release_stall", 32'(stall), 0);
        chk("lu_release_sel1", 32'(fwd_sel_rs1), 2);
        tick();

        // x0 and unused operands
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        #1 chk("x0_sel1", 32'(fwd_sel_rs1), 0);
        tick();
        drive(1, 0, 0, 0, 0, 9, 1, 1, 0);
        tick();
        drive(1, 0, 0, 9, 0, 0, 0, 0, 0);
        #1 chk("unused_stall", 32'(stall), 0);
        chk("unused_sel2", 32'(fwd_sel_rs2), 0);
        tick();

        // Youngest wins
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        tick();
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        #1 chk("young_sel1", 32'(fwd_sel_rs1), 1);
        tick();

        // Flush vs stall
        idle();
        tick();
        tick();
        drive(1, 0, 0, 0, 0, 4, 1, 1, 0);
        tick();
        drive(1, 4, 1, 0, 0, 10, 1, 0, 1);
        #1 chk("fl_flush", 32'(flush), 1);
        chk("fl_stall", 32'(stall), 0);
        chk("fl_bubble", 32'(bubble), 1);
        tick();
        chk("fl_flush_cnt", 32'(flush_cnt), 1);
        chk("fl_stall_cnt_kept", 32'(stall_cnt), 1);
        drive(1, 10, 1, 4, 1, 0, 0, 0, 0);
        #1 chk("fl_killed_sel1", 32'(fwd_sel_rs1), 0);
        chk("fl_load_sel2", 32'(fwd_sel_rs2), 2);
        chk("fl_after_stall", 32'(stall), 0);
        tick();

        // Async reset mid-stall
        idle();
        tick();
        drive(1, 0, 0, 0, 0, 11, 1, 1, 0);
        tick();
        drive(1, 11, 1, 0, 0, 0, 0, 0, 0);
        #1 chk("ar_stall_before", 32'(stall), 1);
        reset = 1'b0;
        #1 chk("ar_stall", 32'(stall), 0);
        chk("ar_bubble", 32'(bubble), 0);
        chk("ar_stall_cnt", 32'(stall_cnt), 0);
        chk("ar_flush_cnt", 32'(flush_cnt), 0);
        chk("ar_sel1", 32'(fwd_sel_rs1), 0);
        reset = 1'b1;
        idle();
        tick();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        #1 chk("ar_post_sel1", 32'(fwd_sel_rs1), 1);
        chk("ar_post_stall_cnt", 32'(stall_cnt), 0);
        tick();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
